// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction prefetch unit: FSM state encoding
// and default parameter values.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } fetch_state_e;

  localparam int DEF_PC_W     = 10;
  localparam int DEF_INSTR_W  = 16;
  localparam int DEF_DEPTH    = 4;
  localparam int DEF_RESET_PC = 0;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding {pc, instruction} pairs; flush clears it in one
// cycle and takes priority over a simultaneous push or pop.
module fetch_fifo #(
  parameter int W     = 26,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_push,
  input  logic [W-1:0]             i_data,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic [W-1:0]             o_head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign w_pop  = i_pop && (r_count != '0);
  assign w_push = i_push && ((r_count != FULL_CNT) || w_pop);

  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push && !i_flush && !i_reset) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/prefetch_unit.sv
// Instruction prefetcher: single-outstanding fetch FSM feeding a small queue,
// with jump/branch redirects that flush the queue and drop stale responses.
module prefetch_unit
  import fetch_pkg::*;
#(
  parameter int              PC_W     = DEF_PC_W,
  parameter int              INSTR_W  = DEF_INSTR_W,
  parameter int              DEPTH    = DEF_DEPTH,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEF_RESET_PC)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               halted,
  input  logic               jump,
  input  logic               branch,
  input  logic [PC_W-1:0]    jump_target,
  input  logic [PC_W-1:0]    branch_addr,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ready,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  input  logic               instr_ready
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  fetch_state_e            r_state;
  fetch_state_e            w_state_nxt;
  logic [PC_W-1:0]         r_pc;
  logic [PC_W-1:0]         r_tag;
  logic [PC_W-1:0]         w_redirect_pc;
  logic                    w_redirect;
  logic                    w_accept;
  logic                    w_push;
  logic                    w_pop;
  logic [CW-1:0]           w_count;
  logic [PC_W+INSTR_W-1:0] w_head;

  assign w_redirect    = jump || branch;
  assign w_redirect_pc = jump ? jump_target : branch_addr;

  // Issue is suppressed during reset and in any redirect cycle so the new
  // target is presented on the following cycle.
  assign imem_req  = !reset && (r_state == S_IDLE) && !halted && !w_redirect &&
                     (w_count < FULL_CNT);
  assign imem_addr = r_pc;
  assign w_accept  = imem_req && imem_ready;
  assign w_push    = !reset && (r_state == S_WAIT) && imem_rvalid && !w_redirect;
  assign w_pop     = instr_valid && instr_ready;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = S_WAIT;
        else          w_state_nxt = S_IDLE;
      end
      S_WAIT: begin
        if (w_redirect)       w_state_nxt = S_DISCARD;
        else if (imem_rvalid) w_state_nxt = S_IDLE;
        else                  w_state_nxt = S_WAIT;
      end
      S_DISCARD: begin
        if (imem_rvalid) w_state_nxt = S_IDLE;
        else             w_state_nxt = S_DISCARD;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc  <= RESET_PC;
      r_tag <= RESET_PC;
    end else if (w_redirect) begin
      r_pc <= w_redirect_pc;
    end else if (w_accept) begin
      r_pc  <= r_pc + PC_W'(1);
      r_tag <= r_pc;
    end
  end

  fetch_fifo #(
    .W     (PC_W + INSTR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_reset (reset),
    .i_push  (w_push),
    .i_data  ({r_tag, imem_rdata}),
    .i_pop   (w_pop),
    .i_flush (w_redirect),
    .o_count (w_count),
    .o_head  (w_head)
  );

  assign instr_valid = (w_count != '0);
  assign instr       = w_head[INSTR_W-1:0];
  assign instr_pc    = w_head[PC_W+INSTR_W-1:INSTR_W];

endmodule

// File: tb/tb_prefetch_unit.sv
// Directed bench for prefetch_unit: a main instance with default parameters
// and a second one with RESET_PC=0x3FE sharing the same stimulus.
module tb_prefetch_unit;

  localparam int PC_W    = 10;
  localparam int INSTR_W = 16;
  localparam int DEPTH   = 4;

  logic               clk = 1'b0;
  logic               reset, halted, jump, branch;
  logic [PC_W-1:0]    jump_target, branch_addr;
  logic               imem_ready, imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;
  logic               instr_ready;

  logic               imem_req, imem_req_b;
  logic [PC_W-1:0]    imem_addr, imem_addr_b;
  logic               instr_valid, instr_valid_b;
  logic [INSTR_W-1:0] instr, instr_b;
  logic [PC_W-1:0]    instr_pc, instr_pc_b;

  int n_vec = 0;
  int n_err = 0;
  int n_acc = 0;
  bit mem_manual = 1'b0;

  always #5 clk = ~clk;

  prefetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .reset(reset), .halted(halted), .jump(jump), .branch(branch),
    .jump_target(jump_target), .branch_addr(branch_addr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready)
  );

  prefetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH),
                  .RESET_PC(10'h3FE)) u_dut_wrap (
    .clk(clk), .reset(reset), .halted(halted), .jump(jump), .branch(branch),
    .jump_target(jump_target), .branch_addr(branch_addr),
    .imem_req(imem_req_b), .imem_addr(imem_addr_b), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid_b), .instr(instr_b), .instr_pc(instr_pc_b),
    .instr_ready(instr_ready)
  );

  function automatic logic [INSTR_W-1:0] mem_data(input logic [PC_W-1:0] a);
    return 16'h5A00 ^ {6'd0, a};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample the handshake before the edge, then (unless the bench
  // drives the response by hand) answer an accepted request one cycle later.
  task automatic cycle();
    logic            acc;
    logic [PC_W-1:0] a;
    @(negedge clk);
    acc = imem_req && imem_ready;
    a   = imem_addr;
    @(posedge clk);
    #1;
    if (acc === 1'b1) n_acc++;
    if (!mem_manual) begin
      imem_rvalid = (acc === 1'b1);
      imem_rdata  = mem_data(a);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; halted = 1'b0; jump = 1'b0; branch = 1'b0;
    imem_rvalid = 1'b0; mem_manual = 1'b0;
    cycle();
    check_val("rst_req", imem_req, 0);
    check_val("rst_valid", instr_valid, 0);
    cycle();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [PC_W-1:0] exp_pc, exp_b, exp_ab;
    int got;
    reset = 1'b1; halted = 1'b0; jump = 1'b0; branch = 1'b0;
    jump_target = '0; branch_addr = '0; imem_ready = 1'b1;
    imem_rvalid = 1'b0; imem_rdata = '0; instr_ready = 1'b1;

    // Streaming fetch, plus address wrap on the RESET_PC=0x3FE instance.
    do_reset();
    check_val("first_req", imem_req, 1);
    check_val("first_addr", imem_addr, 0);
    check_val("wrap_first_addr", imem_addr_b, 10'h3FE);
    exp_pc = '0; exp_b = 10'h3FE; exp_ab = 10'h3FE; got = 0;
    for (int i = 0; i < 10; i++) begin
      if (imem_req_b) begin
        check_val("wrap_addr", imem_addr_b, exp_ab);
        exp_ab++;
      end
      cycle();
      if (instr_valid) begin
        check_val("seq_pc", instr_pc, exp_pc);
        check_val("seq_instr", instr, mem_data(exp_pc));
        check_val("wrap_instr", instr_b, mem_data(exp_pc));
        exp_pc++;
        got++;
      end
      if (instr_valid_b) begin
        check_val("wrap_pc", instr_pc_b, exp_b);
        exp_b++;
      end
    end
    check_val("seq_count", got, 5);
    check_val("wrap_last", exp_ab, 10'h003);

    // Queue fills to DEPTH with the consumer stalled, then issue resumes.
    do_reset();
    instr_ready = 1'b0;
    n_acc = 0;
    repeat (12) cycle();
    check_val("fill_accepts", n_acc, DEPTH);
    check_val("fill_req", imem_req, 0);
    check_val("fill_valid", instr_valid, 1);
    check_val("fill_head", instr_pc, 0);
    instr_ready = 1'b1;
    #1;
    check_val("full_hold", imem_req, 0);
    cycle();
    check_val("resume_req", imem_req, 1);
    check_val("resume_addr", imem_addr, 4);
    check_val("fifo_order", instr_pc, 1);

    // Jump and branch together while a request is outstanding.
    do_reset();
    mem_manual = 1'b1;
    instr_ready = 1'b0;
    cycle();
    imem_rvalid = 1'b1; imem_rdata = mem_data(10'd0);
    cycle();
    imem_rvalid = 1'b0;
    check_val("pre_redir_valid", instr_valid, 1);
    cycle();
    jump = 1'b1; jump_target = 10'h200; branch = 1'b1; branch_addr = 10'h100;
    #1;
    check_val("redir_req", imem_req, 0);
    cycle();
    jump = 1'b0; branch = 1'b0;
    #1;
    check_val("flush_valid", instr_valid, 0);
    check_val("discard_req", imem_req, 0);
    imem_rvalid = 1'b1; imem_rdata = mem_data(10'd1);
    cycle();
    imem_rvalid = 1'b0;
    #1;
    check_val("stale_drop", instr_valid, 0);
    check_val("jump_req", imem_req, 1);
    check_val("jump_addr", imem_addr, 10'h200);
    branch = 1'b1; branch_addr = 10'h155;
    #1;
    check_val("branch_idle_req", imem_req, 0);
    cycle();
    branch = 1'b0;
    #1;
    check_val("branch_req", imem_req, 1);
    check_val("branch_addr", imem_addr, 10'h155);

    // halted while waiting: response lands, queue drains, no new issue.
    do_reset();
    instr_ready = 1'b0;
    cycle();
    halted = 1'b1;
    n_acc = 0;
    cycle();
    check_val("halt_push", instr_valid, 1);
    check_val("halt_pc", instr_pc, 0);
    check_val("halt_req", imem_req, 0);
    instr_ready = 1'b1;
    cycle();
    check_val("halt_drain", instr_valid, 0);
    cycle();
    cycle();
    check_val("halt_no_issue", n_acc, 0);
    halted = 1'b0;
    #1;
    check_val("unhalt_req", imem_req, 1);
    check_val("unhalt_addr", imem_addr, 1);

    // Reset while waiting; the late response must be ignored.
    do_reset();
    mem_manual = 1'b1;
    instr_ready = 1'b0;
    cycle();
    imem_rvalid = 1'b1; imem_rdata = mem_data(10'd0);
    cycle();
    imem_rvalid = 1'b0;
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0; imem_ready = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = mem_data(10'd1);
    #1;
    check_val("rst_mid_valid", instr_valid, 0);
    check_val("rst_mid_addr", imem_addr, 0);
    cycle();
    imem_rvalid = 1'b0;
    #1;
    check_val("late_rvalid", instr_valid, 0);
    check_val("late_req", imem_req, 1);
    check_val("late_addr", imem_addr, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/prefetch_unit.md
PREFETCH_UNIT -- requirements
Module: prefetch_unit

Interface
REQ-001 Parameter PC_W, default 10, PC and instruction-memory address width.
REQ-002 Parameter INSTR_W, default 16, instruction word width.
REQ-003 Parameter DEPTH, default 4, prefetch queue entries; power of two, >=2.
REQ-004 Parameter RESET_PC, default 0, fetch PC after reset.
REQ-005 Port clk  in  1  single clock; all state updates on rising edge.
REQ-006 Port reset  in  1  synchronous, active-high reset.
REQ-007 Port halted  in  1  when high, no new memory requests are issued.
REQ-008 Port jump  in  1  redirect to jump_target; priority over branch.
REQ-009 Port branch  in  1  redirect to branch_addr.
REQ-010 Port jump_target  in  PC_W  jump destination.
REQ-011 Port branch_addr  in  PC_W  branch destination.
REQ-012 Port imem_req  out  1  request valid.
REQ-013 Port imem_addr  out  PC_W  request address; equals fetch PC.
REQ-014 Port imem_ready  in  1  request accepted when imem_req and imem_ready are both high.
REQ-015 Port imem_rvalid  in  1  response valid; at least one cycle after acceptance.
REQ-016 Port imem_rdata  in  INSTR_W  response data.
REQ-017 Port instr_valid  out  1  queue head valid.
REQ-018 Port instr  out  INSTR_W  queue head instruction.
REQ-019 Port instr_pc  out  PC_W  PC of queue head.
REQ-020 Port instr_ready  in  1  consumer pops head when instr_valid and instr_ready are both high.

Function
REQ-021 States: IDLE (nothing outstanding), WAIT (one request outstanding), DISCARD (outstanding response to be dropped). At most one request outstanding.
REQ-022 imem_req is high only in IDLE with halted=0, jump=0, branch=0, and queue count < DEPTH.
REQ-023 Request accepted: IDLE->WAIT; the PC is latched as the tag; fetch PC increments modulo 2^PC_W (max wraps to 0).
REQ-024 In WAIT, imem_rvalid pushes {tag, imem_rdata} into the queue in that cycle; WAIT->IDLE.
REQ-025 Redirect (jump or branch high): fetch PC <= jump ? jump_target : branch_addr; queue flushed (count=0); WAIT->DISCARD; an imem_rvalid in the same cycle is dropped.
REQ-026 DISCARD: the next imem_rvalid is dropped; DISCARD->IDLE. A redirect in DISCARD updates the PC only.
REQ-027 imem_rvalid in IDLE is ignored.
REQ-028 First request after a redirect from IDLE: imem_req is high in cycle N+1 with imem_addr = target.
REQ-029 instr_valid = (count != 0); instr and instr_pc are driven from the queue head; the queue is first-in-first-out.
REQ-030 A push and a pop in the same cycle leave count unchanged. A push when full is impossible by REQ-022.
REQ-031 A redirect in the same cycle as a pop or a push: the flush wins; count becomes 0.
REQ-032 halted blocks issue only. An outstanding response still completes, the queue still drains, and redirects still apply.

Reset
REQ-033 When reset is high at a clock edge: fetch PC=RESET_PC, state=IDLE, count=0, queue pointers=0.
REQ-034 During and after reset: imem_req=0 and instr_valid=0. instr and instr_pc are don't-care while instr_valid=0.
REQ-035 Reset mid-operation abandons any outstanding request; a late imem_rvalid is ignored (REQ-027).
REQ-036 Reset has priority over redirect, halted and all handshakes.

Structure
REQ-037 Shared package fetch_pkg holds the state encoding (IDLE/WAIT/DISCARD) and the default parameter constants.
REQ-038 Sub-module fetch_fifo: synchronous FIFO, width PC_W+INSTR_W, depth DEPTH, with push, pop, flush, count, and head outputs.
REQ-039 The FSM, fetch PC register and request logic reside in prefetch_unit.

Verification
REQ-040 Reset, then imem_ready=1 with rvalid one cycle after each accept and instr_ready=1 -> instr_pc sequence 0,1,2,3… with matching instr.
REQ-041 instr_ready=0, memory always ready -> exactly DEPTH entries, then imem_req=0. Set instr_ready=1 -> issue resumes next cycle.
REQ-042 jump=1, jump_target=0x200, and branch=1, branch_addr=0x100, in the same cycle with WAIT outstanding -> queue empty, the stale response dropped, next imem_addr=0x200.
REQ-043 RESET_PC=0x3FE, PC_W=10 -> request addresses 0x3FE, 0x3FF, 0x000.
REQ-044 halted=1 while in WAIT -> the response is pushed, no further imem_req, and the queue drains. halted=0 -> issue resumes at the next PC.
REQ-045 reset asserted in WAIT, then rvalid arrives -> instr_valid stays 0 and the first request uses RESET_PC.
